// File: rtl/serial_pkg.sv
// Shared types and constants for the serial-adder sequencer.
package serial_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPT,
    HOLD
  } seq_state_t;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Clearable up-counter that flags the last of WIDTH counts.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == LAST);

endmodule

// File: rtl/serial_add_seq.sv
// Operand sequencer and result collector for the bit-serial adder.
// Define SERIAL_SEQ_OVF_EN to report the carry-out of each addition on res_ovf.
module serial_add_seq
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             load,
  output logic             shift,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ovf
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             w_accept;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic             w_tc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res_sum;

  assign w_accept  = (r_state == IDLE) && op_valid;
  assign w_cnt_en  = (r_state == SHIFT);
  assign w_cnt_clr = ~w_cnt_en;

  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_cnt (
    .i_clk(clk),
    .i_rst(reset),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IDLE accept | LOAD adder load | SHIFT WIDTH shifts | CAPT sample sum | HOLD offer result
  always_comb begin
    w_state_nxt = r_state;
    op_ready    = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) w_state_nxt = LOAD;
      end
      LOAD: begin
        load        = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (w_tc) w_state_nxt = CAPT;
      end
      CAPT: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res_sum <= '0;
    end else begin
      if (w_accept) begin
        r_a <= op_a;
        r_b <= op_b;
      end
      if (r_state == CAPT) begin
        r_res_sum <= sum;
      end
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign res_sum = r_res_sum;

`ifdef SERIAL_SEQ_OVF_EN
  logic [WIDTH:0] w_wide_sum;
  logic           w_done;
  logic           r_carry;
  logic           r_res_ovf;

  // Carry is taken from the accepted operands so it lines up with the captured sum.
  assign w_wide_sum = {1'b0, op_a} + {1'b0, op_b};
  assign w_done     = (r_state == HOLD) && res_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_carry   <= 1'b0;
      r_res_ovf <= 1'b0;
    end else begin
      if (w_accept) r_carry <= w_wide_sum[WIDTH];
      if (r_state == CAPT) begin
        r_res_ovf <= r_carry;
      end else if (w_done) begin
        r_res_ovf <= 1'b0;
      end
    end
  end

  assign res_ovf = r_res_ovf;
`else
  assign res_ovf = 1'b0;
`endif

endmodule
